// File: rtl/store_buffer.sv
// Posted-write store buffer between EX/MEM and the single-ported data memory.
// Define SB_FWD_EN to forward buffered store data to loads; otherwise hitting loads stall.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          MemWriteM,
    input  logic          MemReadM,
    input  logic [31:0]   ALUOutM,
    input  logic [31:0]   WriteDataM,
    input  logic [31:0]   MemRData,
    output logic          MemWE,
    output logic [31:0]   MemAddr,
    output logic [31:0]   MemWData,
    output logic [31:0]   ReadDataM,
    output logic          StallM,
    output logic [CW-1:0] Count,
    output logic          Empty
);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic             hit;
    logic             load_stall;
    logic             store_stall;
    logic             stall;
    logic             drain;
    logic             enq;
`ifdef SB_FWD_EN
    logic [31:0]      hit_data;
`endif

    assign Count = count_q;
    assign Empty = (count_q == '0);

    // Walk entries oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit = 1'b0;
`ifdef SB_FWD_EN
        hit_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (valid_q[rd_ptr + PW'(k)] && (addr_q[rd_ptr + PW'(k)] == ALUOutM)) begin
                hit = 1'b1;
`ifdef SB_FWD_EN
                hit_data = data_q[rd_ptr + PW'(k)];
`endif
            end
        end
    end

`ifdef SB_FWD_EN
    assign load_stall = 1'b0;
    assign drain      = !Empty && !MemReadM;
    assign ReadDataM  = hit ? hit_data : MemRData;
`else
    // A hitting load waits while the buffer drains past the matching entries.
    assign load_stall = MemReadM && hit;
    assign drain      = !Empty && (!MemReadM || load_stall);
    assign ReadDataM  = MemRData;
`endif

    assign store_stall = MemWriteM && (count_q == CW'(DEPTH)) && !drain;
    assign stall       = store_stall || load_stall;
    assign enq         = MemWriteM && !stall;
    assign StallM      = rst ? 1'b0 : stall;

    always_comb begin
        MemWE    = 1'b0;
        MemAddr  = addr_q[rd_ptr];
        MemWData = data_q[rd_ptr];
        if (rst) begin
            MemAddr  = '0;
            MemWData = '0;
        end else if (drain) begin
            MemWE = 1'b1;
        end else if (MemReadM) begin
            MemAddr = ALUOutM;
        end
    end

    // Enqueue is applied after drain so a full buffer refilling its head slot keeps it valid.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (drain) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            if (enq) begin
                addr_q[wr_ptr]  <= ALUOutM;
                data_q[wr_ptr]  <= WriteDataM;
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(drain);
        end
    end
endmodule
